// File: rtl/seg_scan_display_if.sv
// Load/ready handshake and status bundle between the ALU result
// path and the scanned 7-segment display driver.
interface seg_scan_display_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] value;
  logic             load;
  logic             blank_en;
  logic             ready;
  logic             done;
  logic             overflow;

  modport master (
    output value, load, blank_en,
    input  ready, done, overflow
  );

  modport slave (
    input  value, load, blank_en,
    output ready, done, overflow
  );
endinterface

// File: rtl/seg_scan_display.sv
// Sequential binary-to-BCD converter feeding a time-multiplexed
// 7-segment display with sign digit, zero blanking and overflow.
module seg_scan_display #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 10000,
  parameter bit SIGNED   = 1'b1
) (
  input  logic              clock,
  input  logic              Reset,
  seg_scan_display_if.slave bus,
  output logic [DIGITS-1:0] AN,
  output logic [6:0]        SEG
);

  // decimal digits of 2^WIDTH-1, plus one spare
  localparam int NBD = (WIDTH * 30103) / 100000 + 2;
  localparam int NB  = (NBD > DIGITS) ? NBD : DIGITS;
  localparam int DD  = SIGNED ? DIGITS - 1 : DIGITS;
  localparam int CW  = $clog2(WIDTH);
  localparam int PW  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int IW  = $clog2(DIGITS);

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    COMMIT
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]  mag_q, mag_d;
  logic [4*NB-1:0]   bcd_q, bcd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic [6:0]        disp_q [DIGITS];
  logic [6:0]        disp_d [DIGITS];
  logic              ovf_c;
  logic [4*NB-1:0]   adj;
  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DIGITS-1:0] an_q;
  logic [6:0]        seg_q;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NB; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    logic       hi_zero;
    logic [3:0] nib;
    logic [6:0] code;
    ovf_c   = 1'b0;
    hi_zero = 1'b1;
    nib     = '0;
    code    = SEG_BLANK;
    for (int i = DD; i < NB; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) ovf_c = 1'b1;
    end
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib  = bcd_q[4*i +: 4];
      code = seg_of(nib);
      if (i >= DD) begin
        code = neg_q ? SEG_DASH : SEG_BLANK;
      end else begin
        if (i > 0 && bus.blank_en && hi_zero && nib == 4'd0)
          code = SEG_BLANK;
        if (nib != 4'd0) hi_zero = 1'b0;
      end
      if (ovf_c) code = SEG_DASH;
      disp_d[i] = code;
    end
  end

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.load) begin
          neg_d   = SIGNED && bus.value[WIDTH-1];
          mag_d   = neg_d ? (~bus.value + 1'b1) : bus.value;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        bcd_d = {adj[4*NB-2:0], mag_q[WIDTH-1]};
        mag_d = {mag_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = COMMIT;
      end
      COMMIT: begin
        ovf_d   = ovf_c;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  // all digits swap in one edge, so a scan never mixes two values
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DIGITS; i++)
        disp_q[i] <= (i == 0) ? SEG_ZERO : SEG_BLANK;
    end else if (state_q == COMMIT) begin
      for (int i = 0; i < DIGITS; i++)
        disp_q[i] <= disp_d[i];
    end
  end

  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      seg_q   <= SEG_BLANK;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= ~(DIGITS'(1) << idx_q);
      seg_q   <= disp_q[idx_q];
    end
  end

  assign bus.ready    = (state_q == IDLE);
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign AN           = an_q;
  assign SEG          = seg_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench: signed 4-digit instance and unsigned 2-digit
// instance, checked against hand-computed segment codes.
module tb_seg_scan_display;

  logic clock = 1'b0;
  logic Reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  seg_scan_display_if #(.WIDTH(8)) bus_a ();
  seg_scan_display_if #(.WIDTH(8)) bus_b ();

  logic [3:0] an_a;
  logic [6:0] seg_a;
  logic [1:0] an_b;
  logic [6:0] seg_b;

  seg_scan_display #(
    .WIDTH(8), .DIGITS(4), .SCAN_DIV(4), .SIGNED(1'b1)
  ) dut_a (
    .clock(clock), .Reset(Reset), .bus(bus_a.slave),
    .AN(an_a), .SEG(seg_a)
  );

  seg_scan_display #(
    .WIDTH(8), .DIGITS(2), .SCAN_DIV(4), .SIGNED(1'b0)
  ) dut_b (
    .clock(clock), .Reset(Reset), .bus(bus_b.slave),
    .AN(an_b), .SEG(seg_b)
  );

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] SB = 7'b1111111;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_load(input int sel, input logic [7:0] v);
    @(negedge clock);
    if (sel == 0) begin
      bus_a.value = v; bus_a.load = 1'b1;
    end else begin
      bus_b.value = v; bus_b.load = 1'b1;
    end
    @(negedge clock);
    bus_a.load = 1'b0;
    bus_b.load = 1'b0;
  endtask

  // edges from the one sampling load up to the one raising done
  task automatic wait_done(input int sel, output int n);
    logic d, r;
    n = 1;
    d = (sel == 0) ? bus_a.done : bus_b.done;
    while (!d && n < 40) begin
      r = (sel == 0) ? bus_a.ready : bus_b.ready;
      if (r) check("ready_low", r, 0);
      @(negedge clock);
      n++;
      d = (sel == 0) ? bus_a.done : bus_b.done;
    end
    if (!d) check("done_timeout", 0, 1);
  endtask

  task automatic read_digit(input int sel, input int k,
                            output logic [6:0] s);
    int t;
    logic hit;
    t = 0;
    hit = 1'b0;
    s = 'x;
    while (!hit && t < 40) begin
      @(negedge clock);
      t++;
      if (sel == 0 && an_a == ~(4'(1) << k)) begin
        hit = 1'b1; s = seg_a;
      end
      if (sel == 1 && an_b == ~(2'(1) << k)) begin
        hit = 1'b1; s = seg_b;
      end
    end
    if (!hit) check("scan_timeout", 0, 1);
  endtask

  task automatic show_a(input string tag, input logic [6:0] d3,
                        input logic [6:0] d2, input logic [6:0] d1,
                        input logic [6:0] d0);
    logic [6:0] s;
    read_digit(0, 3, s); check({tag, "_d3"}, s, d3);
    read_digit(0, 2, s); check({tag, "_d2"}, s, d2);
    read_digit(0, 1, s); check({tag, "_d1"}, s, d1);
    read_digit(0, 0, s); check({tag, "_d0"}, s, d0);
  endtask

  initial begin
    int n;
    int pulses;
    logic [6:0] s;
    logic [3:0] exp_an;
    bus_a.value = '0; bus_a.load = 1'b0; bus_a.blank_en = 1'b1;
    bus_b.value = '0; bus_b.load = 1'b0; bus_b.blank_en = 1'b1;

    repeat (3) @(negedge clock);
    check("rst_ready", bus_a.ready, 1);
    check("rst_done", bus_a.done, 0);
    check("rst_ovf", bus_a.overflow, 0);
    check("rst_an", an_a, 4'b1111);
    check("rst_seg", seg_a, 7'h7F);
    Reset = 1'b1;

    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      exp_an = ~(4'(1) << (((c - 1) / 4) % 4));
      check($sformatf("scan_an_%0d", c), an_a, exp_an);
      if (c == 1) check("scan_d0_zero", seg_a, S0);
    end

    do_load(0, 8'h80);
    wait_done(0, n);
    check("lat_80", n, 10);
    check("ready_after", bus_a.ready, 1);
    @(negedge clock);
    check("done_one_cycle", bus_a.done, 0);
    check("ovf_80", bus_a.overflow, 0);
    show_a("v80", SD, S1, S2, S8);

    do_load(0, 8'd5);
    wait_done(0, n);
    show_a("v5_blank", SB, SB, SB, S5);

    bus_a.blank_en = 1'b0;
    do_load(0, 8'd5);
    wait_done(0, n);
    show_a("v5_noblank", SB, S0, S0, S5);
    bus_a.blank_en = 1'b1;

    do_load(0, 8'hFF);
    pulses = 0;
    repeat (2) begin
      @(negedge clock);
      pulses += int'(bus_a.done);
    end
    bus_a.value = 8'd7; bus_a.load = 1'b1;
    @(negedge clock);
    pulses += int'(bus_a.done);
    bus_a.load = 1'b0;
    repeat (20) begin
      @(negedge clock);
      pulses += int'(bus_a.done);
    end
    check("ign_pulses", pulses, 1);
    check("ign_ready", bus_a.ready, 1);
    read_digit(0, 0, s); check("neg1_d0", s, S1);
    read_digit(0, 3, s); check("neg1_d3", s, SD);

    do_load(0, 8'd100);
    repeat (3) @(negedge clock);
    Reset = 1'b0;
    @(negedge clock);
    Reset = 1'b1;
    check("abort_ready", bus_a.ready, 1);
    pulses = 0;
    repeat (20) begin
      @(negedge clock);
      pulses += int'(bus_a.done);
    end
    check("abort_nodone", pulses, 0);
    check("abort_ovf", bus_a.overflow, 0);
    read_digit(0, 0, s); check("abort_d0", s, S0);

    do_load(1, 8'd255);
    wait_done(1, n);
    check("u255_lat", n, 10);
    check("u255_ovf", bus_b.overflow, 1);
    read_digit(1, 1, s); check("u255_d1", s, SD);
    read_digit(1, 0, s); check("u255_d0", s, SD);

    do_load(1, 8'd99);
    wait_done(1, n);
    check("u99_ovf", bus_b.overflow, 0);
    read_digit(1, 1, s); check("u99_d1", s, S9);
    read_digit(1, 0, s); check("u99_d0", s, S9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
